// File: rtl/swap_datapath_pkg.sv
// rtl/swap_datapath_pkg.sv - shared encodings for the swap datapath and its sequence monitor
package swap_datapath_pkg;

  typedef enum logic [1:0] {
    M_IDLE = 2'b00,
    M_S1   = 2'b01,
    M_S2   = 2'b10
  } mon_state_t;

  // Strobe vectors are packed as {H1,H2,H3,C1,C2,C3,Done}
  localparam logic [6:0] PAT_NONE = 7'b000_000_0;
  localparam logic [6:0] PAT_P1   = 7'b010_001_0;
  localparam logic [6:0] PAT_P2   = 7'b100_010_0;
  localparam logic [6:0] PAT_P3   = 7'b001_100_1;

endpackage

// File: rtl/swap_seq_monitor.sv
// rtl/swap_seq_monitor.sv - watches the H/C/Done strobes for the P1,P2,P3 swap sequence
module swap_seq_monitor
  import swap_datapath_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       strobes,
  input  logic             err_clr,
  output logic             swap_done,
  output logic [CNT_W-1:0] swap_count,
  output logic             seq_err
);

  mon_state_t       r_state;
  mon_state_t       w_next;
  logic             w_done_ev;
  logic             w_err_ev;
  logic             r_swap_done;
  logic [CNT_W-1:0] r_swap_count;
  logic             r_seq_err;

  always_ff @(posedge clk) begin
    if (reset) r_state <= M_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_done_ev = 1'b0;
    w_err_ev  = 1'b0;
    case (r_state)
      M_IDLE: begin
        if (strobes == PAT_P1)        w_next = M_S1;
        else if (strobes != PAT_NONE) w_err_ev = 1'b1;
      end
      M_S1: begin
        if (strobes == PAT_P2) begin
          w_next = M_S2;
        end else begin
          w_next   = M_IDLE;
          w_err_ev = 1'b1;
        end
      end
      M_S2: begin
        w_next = M_IDLE;
        if (strobes == PAT_P3) w_done_ev = 1'b1;
        else                   w_err_ev  = 1'b1;
      end
      default: w_next = M_IDLE;
    endcase
  end

  // A fresh violation outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_swap_done  <= 1'b0;
      r_swap_count <= '0;
      r_seq_err    <= 1'b0;
    end else begin
      r_swap_done <= w_done_ev;
      if (w_done_ev && (r_swap_count != {CNT_W{1'b1}}))
        r_swap_count <= r_swap_count + 1'b1;
      r_seq_err <= w_err_ev | (r_seq_err & ~err_clr);
    end
  end

  assign swap_done  = r_swap_done;
  assign swap_count = r_swap_count;
  assign seq_err    = r_seq_err;

endmodule

// File: rtl/swap_datapath.sv
// rtl/swap_datapath.sv - three-register bus datapath driven by the swap controller strobes
module swap_datapath
  import swap_datapath_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             H1,
  input  logic             H2,
  input  logic             H3,
  input  logic             C1,
  input  logic             C2,
  input  logic             C3,
  input  logic             Done,
  input  logic             ld_en,
  input  logic [1:0]       ld_sel,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             err_clr,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] bus,
  output logic             swap_done,
  output logic [CNT_W-1:0] swap_count,
  output logic             conflict_err,
  output logic             seq_err,
  output logic             ld_drop
);

  logic [6:0]       w_strobes;
  logic [1:0]       w_h_cnt;
  logic             w_one_h;
  logic             w_any_c;
  logic             w_conflict;
  logic             w_ld_req;
  logic             w_ld_ok;
  logic             w_ld_drop_ev;
  logic [WIDTH-1:0] w_bus;
  logic [WIDTH-1:0] r_r1;
  logic [WIDTH-1:0] r_r2;
  logic [WIDTH-1:0] r_r3;
  logic             r_conflict_err;
  logic             r_ld_drop;

  assign w_strobes    = {H1, H2, H3, C1, C2, C3, Done};
  assign w_h_cnt      = {1'b0, H1} + {1'b0, H2} + {1'b0, H3};
  assign w_one_h      = (w_h_cnt == 2'd1);
  assign w_any_c      = C1 | C2 | C3;
  assign w_conflict   = (w_h_cnt > 2'd1) | (w_any_c & (w_h_cnt == 2'd0));
  assign w_ld_req     = ld_en & (ld_sel != 2'd0);
  assign w_ld_ok      = w_ld_req & ~(|w_strobes);
  assign w_ld_drop_ev = w_ld_req & (|w_strobes);

  always_comb begin
    w_bus = '0;
    if (w_one_h) begin
      if (H1)      w_bus = r_r1;
      else if (H2) w_bus = r_r2;
      else         w_bus = r_r3;
    end
  end

  // Host loads only happen with every strobe low, so they never race a capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_r1 <= '0;
      r_r2 <= '0;
      r_r3 <= '0;
    end else if (w_one_h) begin
      if (C1) r_r1 <= w_bus;
      if (C2) r_r2 <= w_bus;
      if (C3) r_r3 <= w_bus;
    end else if (w_ld_ok) begin
      case (ld_sel)
        2'd1:    r_r1 <= ld_data;
        2'd2:    r_r2 <= ld_data;
        2'd3:    r_r3 <= ld_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict_err <= 1'b0;
      r_ld_drop      <= 1'b0;
    end else begin
      r_conflict_err <= w_conflict   | (r_conflict_err & ~err_clr);
      r_ld_drop      <= w_ld_drop_ev | (r_ld_drop      & ~err_clr);
    end
  end

  swap_seq_monitor #(
    .CNT_W (CNT_W)
  ) u_mon (
    .clk        (clk),
    .reset      (reset),
    .strobes    (w_strobes),
    .err_clr    (err_clr),
    .swap_done  (swap_done),
    .swap_count (swap_count),
    .seq_err    (seq_err)
  );

  assign r1           = r_r1;
  assign r2           = r_r2;
  assign r3           = r_r3;
  assign bus          = w_bus;
  assign conflict_err = r_conflict_err;
  assign ld_drop      = r_ld_drop;

endmodule

// File: tb/tb_swap_datapath.sv
// tb/tb_swap_datapath.sv - directed self-checking bench for swap_datapath
module tb_swap_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic       H1, H2, H3, C1, C2, C3, Done;
  logic       ld_en;
  logic [1:0] ld_sel;
  logic [7:0] ld_data;
  logic       err_clr;
  logic [7:0] r1, r2, r3, bus;
  logic       swap_done;
  logic [7:0] swap_count;
  logic       conflict_err, seq_err, ld_drop;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] S_NONE = 7'b000_000_0;
  localparam logic [6:0] S_P1   = 7'b010_001_0;
  localparam logic [6:0] S_P2   = 7'b100_010_0;
  localparam logic [6:0] S_P3   = 7'b001_100_1;
  localparam logic [6:0] S_CONF = 7'b110_001_0;

  always #5 clk = ~clk;

  swap_datapath #(.WIDTH(8), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .H1           (H1),
    .H2           (H2),
    .H3           (H3),
    .C1           (C1),
    .C2           (C2),
    .C3           (C3),
    .Done         (Done),
    .ld_en        (ld_en),
    .ld_sel       (ld_sel),
    .ld_data      (ld_data),
    .err_clr      (err_clr),
    .r1           (r1),
    .r2           (r2),
    .r3           (r3),
    .bus          (bus),
    .swap_done    (swap_done),
    .swap_count   (swap_count),
    .conflict_err (conflict_err),
    .seq_err      (seq_err),
    .ld_drop      (ld_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [6:0] v);
    {H1, H2, H3, C1, C2, C3, Done} = v;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string tag, input logic [2:0] exp);
    chk(tag, 32'({conflict_err, seq_err, ld_drop}), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; strobe(S_NONE);
    ld_en = 1'b0; ld_sel = 2'd0; ld_data = 8'h00; err_clr = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst_regs", 32'({r1, r2, r3}), 32'h000000);
    chk("rst_bus", 32'(bus), 32'h0);
    chk("rst_cnt", 32'({swap_done, swap_count}), 32'h0);
    flags("rst_flags", 3'b000);

    ld_en = 1'b1;
    ld_sel = 2'd1; ld_data = 8'h11; cyc();
    ld_sel = 2'd2; ld_data = 8'h22; cyc();
    ld_sel = 2'd3; ld_data = 8'h33; cyc();
    ld_en = 1'b0; ld_sel = 2'd0;
    chk("load_regs", 32'({r1, r2, r3}), 32'h112233);
    flags("load_flags", 3'b000);

    strobe(S_P1); #1;
    chk("bus_h2", 32'(bus), 32'h22);
    cyc();
    chk("p1_r3", 32'(r3), 32'h22);
    strobe(S_P2); cyc();
    strobe(S_P3); #1;
    chk("bus_h3", 32'(bus), 32'h22);
    cyc();
    strobe(S_NONE);
    chk("swap_regs", 32'({r1, r2, r3}), 32'h221122);
    chk("swap_done_hi", 32'(swap_done), 32'h1);
    chk("swap_cnt1", 32'(swap_count), 32'h1);
    flags("swap_flags", 3'b000);
    cyc();
    chk("swap_done_lo", 32'(swap_done), 32'h0);

    strobe(S_CONF); #1;
    chk("conf_bus", 32'(bus), 32'h0);
    cyc();
    chk("conf_r3", 32'(r3), 32'h22);
    flags("conf_flags", 3'b110);
    err_clr = 1'b1; cyc();
    flags("conf_clr_race", 3'b110);
    strobe(S_NONE); cyc();
    err_clr = 1'b0;
    flags("conf_clr", 3'b000);

    strobe(S_P1); cyc();
    chk("brk_p1_r3", 32'(r3), 32'h11);
    flags("brk_p1_flags", 3'b000);
    strobe(S_NONE); cyc();
    flags("brk_none_seq", 3'b010);
    strobe(S_P2); cyc();
    strobe(S_NONE);
    chk("brk_p2_r2", 32'(r2), 32'h22);
    chk("brk_cnt", 32'(swap_count), 32'h1);
    chk("brk_done", 32'(swap_done), 32'h0);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    flags("brk_clr", 3'b000);

    ld_en = 1'b1; ld_sel = 2'd2; ld_data = 8'h5A;
    strobe(S_P1); cyc();
    ld_en = 1'b0; ld_sel = 2'd0;
    chk("drop_r2", 32'(r2), 32'h22);
    flags("drop_flags", 3'b001);
    strobe(S_P2); cyc();
    chk("drop_p2_r2", 32'(r2), 32'h22);
    reset = 1'b1; strobe(S_P3); cyc();
    reset = 1'b0; strobe(S_NONE);
    chk("mid_rst_regs", 32'({r1, r2, r3}), 32'h000000);
    chk("mid_rst_cnt", 32'({swap_done, swap_count}), 32'h0);
    flags("mid_rst_flags", 3'b000);
    cyc();
    chk("mid_rst_done", 32'({swap_done, swap_count}), 32'h0);
    flags("mid_rst_flags2", 3'b000);

    ld_en = 1'b1; ld_sel = 2'd0; ld_data = 8'hFF; cyc();
    ld_en = 1'b0;
    chk("sel0_regs", 32'({r1, r2, r3}), 32'h000000);
    flags("sel0_flags", 3'b000);

    for (int i = 0; i < 255; i++) begin
      strobe(S_P1); cyc();
      strobe(S_P2); cyc();
      strobe(S_P3); cyc();
    end
    strobe(S_NONE);
    chk("cnt_255", 32'(swap_count), 32'hFF);
    cyc();
    strobe(S_P1); cyc();
    strobe(S_P2); cyc();
    strobe(S_P3); cyc();
    strobe(S_NONE);
    chk("sat_done", 32'(swap_done), 32'h1);
    chk("sat_cnt", 32'(swap_count), 32'hFF);
    flags("sat_flags", 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
